// File: rtl/ext_pkg.sv
// Shared definitions for the load-extend pipeline.
//   size_e     : access-size encoding carried on InSize
//   ENTRY_ERR_W: width of the error bit stored with each result
//                (1 with LOAD_EXTEND_ALIGN_CHECK_EN defined, else 0)
//   entry_w()  : packed entry width {data, err} for a given datapath width
package ext_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

`ifdef LOAD_EXTEND_ALIGN_CHECK_EN
    localparam int unsigned ENTRY_ERR_W = 1;
`else
    localparam int unsigned ENTRY_ERR_W = 0;
`endif

    function automatic int unsigned entry_w(input int unsigned data_w);
        return data_w + ENTRY_ERR_W;
    endfunction

endpackage

// File: rtl/ext_lane.sv
// Combinational lane select and zero/sign extension.
// Ports:
//   in_data   : raw memory word
//   offset    : byte offset of the access within the word
//   size      : size_e encoding (byte/half/word/reserved)
//   is_signed : 1 = sign-extend, 0 = zero-extend (ignored for word)
//   ext_data  : extended result
//   ext_err   : misaligned/reserved flag (present only with
//               LOAD_EXTEND_ALIGN_CHECK_EN defined)
module ext_lane
    import ext_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic [DATA_W-1:0]           in_data,
    input  logic [$clog2(DATA_W/8)-1:0] offset,
    input  logic [1:0]                  size,
    input  logic                        is_signed,
    output logic [DATA_W-1:0]           ext_data
`ifdef LOAD_EXTEND_ALIGN_CHECK_EN
    ,
    output logic                        ext_err
`endif
);

    localparam int unsigned OFF_W = $clog2(DATA_W / 8);
    localparam int unsigned IDX_W = OFF_W + 3;

    logic [OFF_W-1:0] half_off;
    logic [IDX_W-1:0] byte_lo;
    logic [IDX_W-1:0] half_lo;
    logic [7:0]       byte_lane;
    logic [15:0]      half_lane;

    always_comb begin
        // Halfword selection ignores off[0]; the pair starts at an even byte.
        half_off = {offset[OFF_W-1:1], 1'b0};
        if (BIG_ENDIAN) begin
            // Offset 0 is the most significant byte; a halfword's first byte is its MSB.
            byte_lo = IDX_W'(DATA_W - 8) - {offset, 3'b000};
            half_lo = IDX_W'(DATA_W - 16) - {half_off, 3'b000};
        end else begin
            byte_lo = {offset, 3'b000};
            half_lo = {half_off, 3'b000};
        end
        byte_lane = in_data[byte_lo +: 8];
        half_lane = in_data[half_lo +: 16];

        case (size_e'(size))
            SZ_BYTE: ext_data = {{(DATA_W - 8){is_signed & byte_lane[7]}}, byte_lane};
            SZ_HALF: ext_data = {{(DATA_W - 16){is_signed & half_lane[15]}}, half_lane};
            default: ext_data = in_data;
        endcase
    end

`ifdef LOAD_EXTEND_ALIGN_CHECK_EN
    always_comb begin
        case (size_e'(size))
            SZ_BYTE: ext_err = 1'b0;
            SZ_HALF: ext_err = offset[0];
            SZ_WORD: ext_err = |offset;
            default: ext_err = 1'b1;
        endcase
    end
`endif

endmodule

// File: rtl/load_extend_pipe.sv
// Pipelined load data extender with a 2-entry skid buffer.
// Config macro: LOAD_EXTEND_ALIGN_CHECK_EN (adds registered OutErr).
// Ports:
//   Clk, Rst           : clock, synchronous active-high reset
//   InValid/InReady    : request handshake (InReady is registered)
//   InData             : raw memory word
//   InOffset           : byte offset within the word
//   InSize             : ext_pkg::size_e encoding
//   InSigned           : 1 = sign-extend
//   OutValid/OutReady  : result handshake
//   OutData            : extended result
//   OutErr             : misaligned/reserved flag (0 unless the macro is defined)
module load_extend_pipe
    import ext_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        InValid,
    output logic                        InReady,
    input  logic [DATA_W-1:0]           InData,
    input  logic [$clog2(DATA_W/8)-1:0] InOffset,
    input  logic [1:0]                  InSize,
    input  logic                        InSigned,
    output logic                        OutValid,
    input  logic                        OutReady,
    output logic [DATA_W-1:0]           OutData,
    output logic                        OutErr
);

    localparam int unsigned ENTRY_W = entry_w(DATA_W);

    logic [DATA_W-1:0]  lane_data;
    logic [ENTRY_W-1:0] lane_entry;

    // entry0 is the output register, entry1 the skid slot.
    logic [ENTRY_W-1:0] ent0_q, ent0_d;
    logic [ENTRY_W-1:0] ent1_q, ent1_d;
    logic               ent0_valid_q, ent0_valid_d;
    logic               ent1_valid_q, ent1_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               in_fire;
    logic               out_fire;

`ifdef LOAD_EXTEND_ALIGN_CHECK_EN
    logic lane_err;

    ext_lane #(
        .DATA_W     (DATA_W),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane (
        .in_data   (InData),
        .offset    (InOffset),
        .size      (InSize),
        .is_signed (InSigned),
        .ext_data  (lane_data),
        .ext_err   (lane_err)
    );

    assign lane_entry = {lane_data, lane_err};
    assign OutErr     = ent0_q[0];
`else
    ext_lane #(
        .DATA_W     (DATA_W),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane (
        .in_data   (InData),
        .offset    (InOffset),
        .size      (InSize),
        .is_signed (InSigned),
        .ext_data  (lane_data)
    );

    assign lane_entry = lane_data;
    assign OutErr     = 1'b0;
`endif

    assign in_fire  = InValid && in_ready_q;
    assign out_fire = ent0_valid_q && OutReady;

    always_comb begin
        ent0_d       = ent0_q;
        ent1_d       = ent1_q;
        ent0_valid_d = ent0_valid_q;
        ent1_valid_d = ent1_valid_q;

        // Drain first, then place any new result in the lowest free slot.
        // An accept is impossible while entry1 is full, so a drained entry1
        // never collides with a new arrival.
        if (out_fire) begin
            if (ent1_valid_q) begin
                ent0_d       = ent1_q;
                ent1_valid_d = 1'b0;
            end else begin
                ent0_valid_d = 1'b0;
            end
        end

        if (in_fire) begin
            if (!ent0_valid_d) begin
                ent0_d       = lane_entry;
                ent0_valid_d = 1'b1;
            end else begin
                ent1_d       = lane_entry;
                ent1_valid_d = 1'b1;
            end
        end

        in_ready_d = !ent1_valid_d;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ent0_q       <= '0;
            ent1_q       <= '0;
            ent0_valid_q <= 1'b0;
            ent1_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            ent0_q       <= ent0_d;
            ent1_q       <= ent1_d;
            ent0_valid_q <= ent0_valid_d;
            ent1_valid_q <= ent1_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign InReady  = in_ready_q;
    assign OutValid = ent0_valid_q;
    assign OutData  = ent0_q[ENTRY_W-1 -: DATA_W];

endmodule

// File: tb/tb_load_extend_pipe.sv
// Self-checking bench for load_extend_pipe (DATA_W=32).
// A little-endian instance carries the main traffic; a big-endian instance
// covers byte-order selection. Honors LOAD_EXTEND_ALIGN_CHECK_EN.
module tb_load_extend_pipe;
    import ext_pkg::*;

    logic        Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Rst, InValid, InReady, InSigned, OutValid, OutReady, OutErr;
    logic [31:0] InData, OutData;
    logic [1:0]  InOffset, InSize;

    logic        be_in_valid, be_in_ready, be_in_signed, be_out_valid, be_out_err;
    logic [31:0] be_in_data, be_out_data;
    logic [1:0]  be_in_offset, be_in_size;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_data_q[$];
    bit          exp_err_q[$];
    logic [31:0] cur_exp;
    bit          cur_err;
    int          cyc = 0;
    int          out_count = 0;
    int          first_out_cyc = -1;
    int          last_out_cyc = -1;
    bit          accepted;

    load_extend_pipe #(.DATA_W(32), .BIG_ENDIAN(1'b0)) dut (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
        .InData(InData), .InOffset(InOffset), .InSize(InSize), .InSigned(InSigned),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData), .OutErr(OutErr)
    );

    load_extend_pipe #(.DATA_W(32), .BIG_ENDIAN(1'b1)) dut_be (
        .Clk(Clk), .Rst(Rst), .InValid(be_in_valid), .InReady(be_in_ready),
        .InData(be_in_data), .InOffset(be_in_offset), .InSize(be_in_size),
        .InSigned(be_in_signed), .OutValid(be_out_valid), .OutReady(1'b1),
        .OutData(be_out_data), .OutErr(be_out_err)
    );

    // Reference: byte k of the word counted from the addressed end, then
    // two's-complement adjustment for a negative lane.
    function automatic logic [31:0] model(input logic [31:0] d, input int unsigned off,
                                          input int unsigned sz, input bit sg, input bit be);
        logic [31:0] v;
        int unsigned base;
        case (sz)
            0: begin
                v = (d >> (8 * (be ? 3 - off : off))) % 256;
                return (sg && v >= 128) ? v - 32'd256 : v;
            end
            1: begin
                base = off - (off % 2);
                v = (d >> (8 * (be ? 2 - base : base))) % 65536;
                return (sg && v >= 32768) ? v - 32'd65536 : v;
            end
            default: return d;
        endcase
    endfunction

    function automatic bit model_err(input int unsigned off, input int unsigned sz);
`ifdef LOAD_EXTEND_ALIGN_CHECK_EN
        return (sz == 1 && off % 2 == 1) || (sz == 2 && off != 0) || sz == 3;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: score handshakes just before the edge, then step past it.
    task automatic tick();
        accepted = 1'b0;
        if (OutValid && OutReady) begin
            chk("out_expected", {31'b0, exp_data_q.size() != 0}, 32'd1);
            if (exp_data_q.size() != 0) begin
                chk("out_data", OutData, exp_data_q.pop_front());
                chk("out_err", {31'b0, OutErr}, {31'b0, exp_err_q.pop_front()});
            end
            out_count++;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
        end
        if (InValid && InReady && !Rst) begin
            exp_data_q.push_back(cur_exp);
            exp_err_q.push_back(cur_err);
            accepted = 1'b1;
        end
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] off, input logic [1:0] sz,
                        input bit sg, input logic [31:0] e, input bit rnd_ready);
        InData = d; InOffset = off; InSize = sz; InSigned = sg; InValid = 1'b1;
        cur_exp = e;
        cur_err = model_err(off, sz);
        for (int i = 0; i < 50; i++) begin
            if (rnd_ready) OutReady = ($urandom_range(0, 3) != 0);
            tick();
            if (accepted) break;
        end
        chk("send_accept", {31'b0, accepted}, 32'd1);
        InValid = 1'b0;
    endtask

    task automatic send_rand(input bit rnd_ready);
        logic [31:0] d;
        logic [1:0]  off, sz;
        bit          sg;
        d = $urandom; off = 2'($urandom_range(0, 3)); sz = 2'($urandom_range(0, 3));
        sg = 1'($urandom_range(0, 1));
        send(d, off, sz, sg, model(d, off, sz, sg, 1'b0), rnd_ready);
    endtask

    task automatic drain();
        OutReady = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (exp_data_q.size() == 0 && !OutValid) break;
            tick();
        end
        chk("drain_empty", exp_data_q.size(), 32'd0);
        chk("drain_outvalid", {31'b0, OutValid}, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  off, sz;
        int          base_count;

        Rst = 1'b1; InValid = 1'b0; InData = '0; InOffset = '0; InSize = '0;
        InSigned = 1'b0; OutReady = 1'b0;
        be_in_valid = 1'b0; be_in_data = '0; be_in_offset = '0; be_in_size = '0;
        be_in_signed = 1'b0;
        cur_exp = '0; cur_err = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_outvalid", {31'b0, OutValid}, 32'd0);
        chk("rst_outdata", OutData, 32'd0);
        chk("rst_outerr", {31'b0, OutErr}, 32'd0);
        chk("rst_inready", {31'b0, InReady}, 32'd1);
        chk("rst_be_inready", {31'b0, be_in_ready}, 32'd1);
        Rst = 1'b0;

        // Byte / half / word extraction, little-endian, one-cycle latency
        OutReady = 1'b1;
        send(32'h80FF_7F01, 2'd1, SZ_BYTE, 1'b1, 32'h0000_007F, 1'b0);
        chk("lat_outvalid", {31'b0, OutValid}, 32'd1);
        chk("lat_outdata", OutData, 32'h0000_007F);
        send(32'h80FF_7F01, 2'd2, SZ_BYTE, 1'b1, 32'hFFFF_FFFF, 1'b0);
        send(32'h80FF_7F01, 2'd3, SZ_BYTE, 1'b0, 32'h0000_0080, 1'b0);
        send(32'h8001_1234, 2'd2, SZ_HALF, 1'b1, 32'hFFFF_8001, 1'b0);
        send(32'h8001_1234, 2'd0, SZ_HALF, 1'b0, 32'h0000_1234, 1'b0);
        send(32'h8001_1234, 2'd0, SZ_WORD, 1'b1, 32'h8001_1234, 1'b0);
        send(32'h8001_1234, 2'd0, SZ_WORD, 1'b0, 32'h8001_1234, 1'b0);
        drain();

        // Big-endian instance
        be_in_valid = 1'b1; be_in_data = 32'h1122_3344; be_in_signed = 1'b0;
        be_in_offset = 2'd0; be_in_size = SZ_BYTE;
        tick();
        chk("be_byte_valid", {31'b0, be_out_valid}, 32'd1);
        chk("be_byte_data", be_out_data, 32'h0000_0011);
        be_in_offset = 2'd2; be_in_size = SZ_HALF;
        tick();
        chk("be_half_data", be_out_data, 32'h0000_3344);
        for (int i = 0; i < 6; i++) begin
            d = $urandom; off = 2'($urandom_range(0, 3)); sz = 2'($urandom_range(0, 3));
            be_in_data = d; be_in_offset = off; be_in_size = sz;
            be_in_signed = 1'($urandom_range(0, 1));
            tick();
            chk("be_rand_data", be_out_data, model(d, off, sz, be_in_signed, 1'b1));
            chk("be_rand_err", {31'b0, be_out_err}, {31'b0, model_err(off, sz)});
        end
        be_in_valid = 1'b0;
        tick();

        // Backpressure: two accepted then InReady drops, order preserved on release
        base_count = out_count;
        OutReady = 1'b0;
        send(32'hA5A5_00F0, 2'd0, SZ_BYTE, 1'b1, 32'hFFFF_FFF0, 1'b0);
        send(32'hA5A5_00F0, 2'd2, SZ_HALF, 1'b0, 32'h0000_A5A5, 1'b0);
        chk("bp_inready_low", {31'b0, InReady}, 32'd0);
        chk("bp_stall_data0", OutData, exp_data_q[0]);
        InData = 32'h1357_9BDF; InOffset = 2'd3; InSize = SZ_BYTE; InSigned = 1'b0;
        InValid = 1'b1; cur_exp = 32'h0000_0013; cur_err = model_err(3, 0);
        tick();
        chk("bp_no_accept", {31'b0, accepted}, 32'd0);
        chk("bp_stall_data1", OutData, exp_data_q[0]);
        chk("bp_stall_valid", {31'b0, OutValid}, 32'd1);
        OutReady = 1'b1;
        send(32'h1357_9BDF, 2'd3, SZ_BYTE, 1'b0, 32'h0000_0013, 1'b0);
        send(32'h1357_9BDF, 2'd1, SZ_HALF, 1'b1, 32'hFFFF_9BDF, 1'b0);
        drain();
        chk("bp_count", out_count - base_count, 32'd4);

        // Streaming: 16 results on 16 consecutive cycles
        base_count = out_count; first_out_cyc = -1; last_out_cyc = -1;
        OutReady = 1'b1;
        for (int i = 0; i < 16; i++) send_rand(1'b0);
        drain();
        chk("stream_count", out_count - base_count, 32'd16);
        chk("stream_span", last_out_cyc - first_out_cyc, 32'd15);

        // Reset with both entries held
        OutReady = 1'b0;
        send(32'hDEAD_BEEF, 2'd0, SZ_WORD, 1'b0, 32'hDEAD_BEEF, 1'b0);
        send(32'hCAFE_F00D, 2'd0, SZ_WORD, 1'b0, 32'hCAFE_F00D, 1'b0);
        chk("rst2_full", {31'b0, InReady}, 32'd0);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        exp_data_q.delete(); exp_err_q.delete();
        chk("rst2_outvalid", {31'b0, OutValid}, 32'd0);
        chk("rst2_inready", {31'b0, InReady}, 32'd1);
        OutReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst2_quiet", {31'b0, OutValid}, 32'd0);
        end

        // Misaligned and reserved accesses (OutErr set only with alignment checking)
        send(32'h8001_1234, 2'd1, SZ_HALF, 1'b0, 32'h0000_1234, 1'b0);
        send(32'h8001_1234, 2'd0, SZ_WORD, 1'b0, 32'h8001_1234, 1'b0);
        send(32'h8001_1234, 2'd2, SZ_WORD, 1'b0, 32'h8001_1234, 1'b0);
        send(32'h8001_1234, 2'd3, SZ_RSVD, 1'b1, 32'h8001_1234, 1'b0);
        drain();

        // Randomized traffic with random backpressure
        for (int i = 0; i < 200; i++) begin
            send_rand(1'b1);
            if ($urandom_range(0, 4) == 0) begin
                OutReady = 1'($urandom_range(0, 1));
                tick();
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
